skew_feeder: RTL and testbench
==============================

# skew_feeder

Input-edge feeder for the systolic processing-element array. It buffers one operand matrix, delivered as K vectors of N words, then drives it into one edge of the array. Lane i is delayed by i cycles, producing the diagonal wavefront the elements expect, and out-of-window slots are zero-filled. It pulses an accumulator-clear before each matrix and a done flag after the last wavefront leaves.

## Interface
- N, 4, number of lanes, i.e. array rows or columns on this edge (N >= 1)
- W, 8, word width in bits, matching element a_in/b_in width
- K, 4, vectors per matrix, i.e. the shared inner dimension (K >= 1)

- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  in_data holds a vector
- in_ready  out  1  feeder accepts a vector this cycle; high only in LOAD
- in_data  in  N*W  vector; element i at bits [i*W +: W]
- clear_out  out  1  one-cycle pulse; zeroes element accumulators before streaming
- lane_out  out  N*W  skewed words to the array edge; lane i at [i*W +: W]
- lane_valid  out  N  bit i high when lane i carries a real word
- done  out  1  one-cycle pulse after the final stream step

## Operation
- FSM states: LOAD, CLEAR, STREAM, DONE.
- LOAD:
  - in_ready = 1.
  - A vector is accepted on each rising edge with in_valid && in_ready. It is stored at buffer row vcnt, then vcnt increments.
  - The edge accepting vector K-1 moves the FSM to CLEAR.
  - Cycles with in_valid low leave the FSM unchanged.
- CLEAR: lasts exactly 1 cycle with clear_out = 1, then moves to STREAM with step t = 0.
- STREAM: lasts K+N-1 cycles, t = 0 .. K+N-2.
  - In step t, lane i outputs buf[t-i][i] with lane_valid[i] = 1 if i <= t < i+K.
  - Otherwise lane i outputs 0 with lane_valid[i] = 0.
  - After t = K+N-2 the FSM moves to DONE.
- DONE: lasts 1 cycle with done = 1, then returns to LOAD with vcnt = 0.
- in_ready = 0 in CLEAR, STREAM and DONE. in_valid is ignored in those states, and no vector is lost or counted.
- The buffer holds K*N*W bits and is written only in LOAD. Contents are not cleared between matrices; stale data must never reach lane_out.
- Counters:
  - vcnt width is clog2(K+1).
  - t width is clog2(K+N).
  - Neither wraps within a matrix; both are reloaded on state entry.
- With N = 1 there is no skew: lane 0 carries vectors 0..K-1 on steps 0..K-1.

## Timing
- Outputs clear_out, lane_out, lane_valid and done are registered. The value for a state or step is visible during the cycle the FSM occupies it.
- in_ready is combinational from state.
- Sequence after the edge accepting the last vector:
  - 1 cycle CLEAR.
  - K+N-1 cycles STREAM.
  - 1 cycle DONE.
  - in_ready rises again on the following cycle.
- Fixed overhead is K+N+1 cycles from the last accept to LOAD re-entry.
- Throughput is one matrix per (load cycles + K+N+1).
- Reset values, applied asynchronously and immediately on reset assertion:
  - FSM = LOAD, vcnt = 0, t = 0.
  - lane_out = 0, lane_valid = 0, clear_out = 0, done = 0.
  - in_ready = 1 once reset deasserts.
- Reset mid-operation, in any state or step: the partial matrix is discarded and outputs are zeroed immediately. No done pulse is issued for the aborted matrix.
- Simultaneous in_valid with the CLEAR, STREAM or DONE transition has no effect.

## Test plan
All scenarios use N=4, K=4, W=8 unless noted. Vector v, element i = (v+1)*16 + i.

- Reset:
  - Stimulus: assert reset with random inputs.
  - Required: lane_out=0, lane_valid=0000, clear_out=0, done=0, in_ready=1 after release.
- Back-to-back load of 4 vectors:
  - clear_out=1 for exactly one cycle.
  - Step 0: lane0=0x10, lane_valid=0001.
  - Step 3: lanes 0..3 = 0x40, 0x31, 0x22, 0x13, valid 1111.
  - Step 6: lane3=0x43, valid 1000.
  - Then done=1 for one cycle, then in_ready=1.
- Gapped in_valid (high every other cycle, 4 vectors): stream is identical to the back-to-back scenario. CLEAR starts the cycle after the 4th accept.
- in_valid held high with garbage data through CLEAR, STREAM and DONE:
  - in_ready=0 throughout; no garbage appears on lanes.
  - The next matrix's first vector is accepted only on the first LOAD cycle.
- Reset pulse at STREAM step 2:
  - Outputs are zero asynchronously and no done pulse occurs.
  - A fresh matrix then streams correctly, with no stale words from the aborted matrix.
- N=1, K=1, vector 0x5A:
  - Sequence: CLEAR, then 1 STREAM cycle with lane0=0x5A and lane_valid=1, then done.

Source files
------------

// File: rtl/skew_feeder_if.sv
// skew_feeder_if: vector load handshake and skewed lane outputs of the skew feeder.
interface skew_feeder_if #(parameter int N = 4, parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           clear_out;
  logic [N*W-1:0] lane_out;
  logic [N-1:0]   lane_valid;
  logic           done;
  modport master (output in_valid, in_data, input in_ready, clear_out, lane_out, lane_valid, done);
  modport slave  (input in_valid, in_data, output in_ready, clear_out, lane_out, lane_valid, done);
endinterface

// File: rtl/skew_feeder.sv
// skew_feeder: buffers K vectors of N words and drives them diagonally skewed onto an array edge.
module skew_feeder #(
    parameter int N = 4,
    parameter int W = 8,
    parameter int K = 4
) (
    input logic clock,
    input logic reset,
    skew_feeder_if.slave bus
);
    localparam int VW = $clog2(K + 1);
    localparam int TW = $clog2(K + N);
    localparam int AW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {LOAD, CLEAR, STREAM, DONE} state_t;

    state_t         state, state_n;
    logic [VW-1:0]  vcnt, vcnt_n;
    logic [TW-1:0]  t, t_n;
    logic [N*W-1:0] mem [K];
    logic [N*W-1:0] lane_n;
    logic [N-1:0]   valid_n;

    assign bus.in_ready = state == LOAD;

    always_comb begin
        state_n = state;
        vcnt_n  = vcnt;
        t_n     = t;
        case (state)
            LOAD:
                if (bus.in_valid) begin
                    vcnt_n = vcnt + VW'(1);
                    if (vcnt == VW'(K - 1)) state_n = CLEAR;
                end
            CLEAR: begin
                state_n = STREAM;
                t_n     = '0;
            end
            STREAM:
                if (t == TW'(K + N - 2)) state_n = DONE;
                else t_n = t + TW'(1);
            DONE: begin
                state_n = LOAD;
                vcnt_n  = '0;
            end
            default: state_n = LOAD;
        endcase
    end

    // Lane i reads vector t-i, so only rows inside the K-wide window are ever selected.
    always_comb begin
        lane_n  = '0;
        valid_n = '0;
        for (int i = 0; i < N; i++)
            if (state_n == STREAM && int'(t_n) >= i && int'(t_n) < i + K) begin
                valid_n[i]         = 1'b1;
                lane_n[i*W +: W]   = mem[AW'(int'(t_n) - i)][i*W +: W];
            end
    end

    always_ff @(posedge clock)
        if (bus.in_ready && bus.in_valid) mem[AW'(vcnt)] <= bus.in_data;

    // Outputs are registered from the next state so they line up with the state being entered.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state          <= LOAD;
            vcnt           <= '0;
            t              <= '0;
            bus.clear_out  <= 1'b0;
            bus.done       <= 1'b0;
            bus.lane_out   <= '0;
            bus.lane_valid <= '0;
        end else begin
            state          <= state_n;
            vcnt           <= vcnt_n;
            t              <= t_n;
            bus.clear_out  <= state_n == CLEAR;
            bus.done       <= state_n == DONE;
            bus.lane_out   <= lane_n;
            bus.lane_valid <= valid_n;
        end
endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: table-driven check of the skewed stream plus reset, gap, garbage and N=K=1 sequences.
module tb_skew_feeder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    skew_feeder_if #(.N(4), .W(8)) bus ();
    skew_feeder_if #(.N(1), .W(8)) bus1 ();

    skew_feeder #(.N(4), .W(8), .K(4)) dut (.clock(clock), .reset(reset), .bus(bus));
    skew_feeder #(.N(1), .W(8), .K(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    typedef struct {
        logic [31:0] lane;
        logic [3:0]  valid;
        logic        clr;
        logic        dn;
        logic        rdy;
    } exp_t;

    exp_t tbl [10];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] vec(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((v + 1) * 16 + i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_matrix(input int gap, input logic [7:0] x);
        for (int v = 0; v < 4; v++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = vec(v) ^ {4{x}};
            tick();
            bus.in_valid = 1'b0;
            bus.in_data  = 32'hFFFF_FFFF;
            if (v < 3) begin
                chk("load_ready", 32'(bus.in_ready), 32'd1);
                chk("load_noclr", 32'(bus.clear_out), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_ready", 32'(bus.in_ready), 32'd1);
                    chk("gap_noclr", 32'(bus.clear_out), 32'd0);
                end
            end
        end
    endtask

    task automatic stream_check(input bit garbage);
        for (int e = 0; e < 10; e++) begin
            chk($sformatf("lane[%0d]", e), bus.lane_out, tbl[e].lane);
            chk($sformatf("valid[%0d]", e), 32'(bus.lane_valid), 32'(tbl[e].valid));
            chk($sformatf("clear[%0d]", e), 32'(bus.clear_out), 32'(tbl[e].clr));
            chk($sformatf("done[%0d]", e), 32'(bus.done), 32'(tbl[e].dn));
            chk($sformatf("ready[%0d]", e), 32'(bus.in_ready), 32'(tbl[e].rdy));
            if (e < 9) begin
                if (garbage) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 32'hDEAD_BEEF;
                end
                tick();
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0010, 4'b0001, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_1120, 4'b0011, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h0012_2130, 4'b0111, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h1322_3140, 4'b1111, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h2332_4100, 4'b1110, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h3342_0000, 4'b1100, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h4300_0000, 4'b1000, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{32'h0000_0000, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1};

        // Reset with random inputs toggling.
        for (int c = 0; c < 3; c++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = $urandom;
            bus1.in_valid = 1'($urandom);
            bus1.in_data  = 8'($urandom);
            tick();
        end
        chk("rst_lane", bus.lane_out, 32'h0);
        chk("rst_valid", 32'(bus.lane_valid), 32'h0);
        chk("rst_clear", 32'(bus.clear_out), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        tick();

        load_matrix(0, 8'h00);
        stream_check(1'b0);

        load_matrix(1, 8'h00);
        stream_check(1'b0);

        load_matrix(0, 8'h00);
        stream_check(1'b1);
        load_matrix(0, 8'h00);
        stream_check(1'b0);

        // Abort a matrix of different data at step 2, then stream a fresh one.
        load_matrix(0, 8'hA5);
        tick();
        tick();
        tick();
        chk("abort_pre_valid", 32'(bus.lane_valid), 32'b0111);
        #2 reset = 1'b1;
        #1;
        chk("abort_lane", bus.lane_out, 32'h0);
        chk("abort_valid", 32'(bus.lane_valid), 32'h0);
        chk("abort_clear", 32'(bus.clear_out), 32'h0);
        chk("abort_done", 32'(bus.done), 32'h0);
        chk("abort_ready", 32'(bus.in_ready), 32'h1);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("abort_nodone", 32'(bus.done), 32'h0);
            chk("abort_idle_valid", 32'(bus.lane_valid), 32'h0);
        end
        load_matrix(0, 8'h00);
        stream_check(1'b0);

        // N=1, K=1 instance.
        bus1.in_valid = 1'b1;
        bus1.in_data  = 8'h5A;
        tick();
        bus1.in_valid = 1'b0;
        chk("n1_clear", 32'(bus1.clear_out), 32'h1);
        chk("n1_clear_valid", 32'(bus1.lane_valid), 32'h0);
        tick();
        chk("n1_lane", 32'(bus1.lane_out), 32'h5A);
        chk("n1_valid", 32'(bus1.lane_valid), 32'h1);
        chk("n1_noclr", 32'(bus1.clear_out), 32'h0);
        tick();
        chk("n1_done", 32'(bus1.done), 32'h1);
        chk("n1_done_lane", 32'(bus1.lane_out), 32'h0);
        chk("n1_done_valid", 32'(bus1.lane_valid), 32'h0);
        tick();
        chk("n1_ready", 32'(bus1.in_ready), 32'h1);
        chk("n1_nodone", 32'(bus1.done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
